// File: rtl/multicycle_controller_pkg.sv
// Purpose: shared encodings for the multi-cycle RV32I control unit, datapath and ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state encoding, opcode constants, mux-select / ALU / immediate codes.
package multicycle_controller_pkg;

  // FETCH must stay at 0 so the reset state is the all-zero encoding.
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } stateT;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_MEMDATA   = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REGA  = 2'b10;

  localparam logic [1:0] SRCB_REGB = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, never on FSM state.
  function automatic logic [1:0] immSrcOf(input logic [6:0] opcode);
    logic [1:0] sel;
    sel = IMM_I;
    case (opcode)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Purpose: control bundle between the multi-cycle controller and the datapath.
// Latency: n/a (wiring only).
// Backpressure: none; the controller owns sequencing.
// master = controller (drives strobes/selects), slave = datapath (drives instruction fields, Zero).
interface multicycle_controller_if;
  logic [6:0] Opcode;
  logic [2:0] Funct3;
  logic       Funct7b5;
  logic       Zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;

  modport master (
    input  Opcode, Funct3, Funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );

  modport slave (
    output Opcode, Funct3, Funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// Purpose: maps ALUOp plus instruction function fields to the ALU operation code.
// Latency: combinational.
// Backpressure: none.
// Ports: ALUOp, Funct3, Funct7b5, Op5 (Opcode[5]) in; ALUControl out.
module alu_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] Funct3,
  input  logic       Funct7b5,
  input  logic       Op5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        case (Funct3)
          // Op5 separates R-type (sub possible) from I-type, where bit 30
          // is part of the immediate and addi must never become sub.
          3'b000:  ALUControl = (Funct7b5 & Op5) ? ALU_SUB : ALU_ADD;
          3'b010:  ALUControl = ALU_SLT;
          3'b100:  ALUControl = ALU_XOR;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_ADD;
        endcase
      end
      default: ALUControl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: Moore FSM sequencing RV32I instructions through fetch/decode/execute/memory/writeback.
// Latency: lw 5, sw/R/I/jal 4, beq 3, unknown opcode 2 cycles per instruction.
// Backpressure: none; one state step per CLK, RESET aborts immediately.
// Ports: CLK, RESET (async, active-high); bus (master side of multicycle_controller_if).
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic                          CLK,
  input  logic                          RESET,
  multicycle_controller_if.master       bus
);

  stateT      state;
  stateT      nextState;
  logic       pcUpdate;
  logic       branch;
  logic       irWriteRaw;
  logic       regWriteRaw;
  logic       memWriteRaw;
  logic [1:0] aluOp;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= FETCH;
    else       state <= nextState;
  end

  always_comb begin
    nextState     = FETCH;
    pcUpdate      = 1'b0;
    branch        = 1'b0;
    irWriteRaw    = 1'b0;
    regWriteRaw   = 1'b0;
    memWriteRaw   = 1'b0;
    aluOp         = ALUOP_ADD;
    bus.AdrSrc    = 1'b0;
    bus.ResultSrc = RES_ALUOUT;
    bus.ALUSrcA   = SRCA_PC;
    bus.ALUSrcB   = SRCB_REGB;
    case (state)
      FETCH: begin
        nextState     = DECODE;
        irWriteRaw    = 1'b1;
        pcUpdate      = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
      end
      DECODE: begin
        // Branch target is precomputed here into ALUOut for BEQ.
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_IMM;
        case (bus.Opcode)
          OP_LOAD, OP_STORE: nextState = MEMADR;
          OP_RTYPE:          nextState = EXECUTER;
          OP_ITYPE:          nextState = EXECUTEI;
          OP_BRANCH:         nextState = BEQ;
          OP_JAL:            nextState = JAL;
          default:           nextState = FETCH;
        endcase
      end
      MEMADR: begin
        bus.ALUSrcA = SRCA_REGA;
        bus.ALUSrcB = SRCB_IMM;
        nextState   = (bus.Opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        nextState  = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = RES_MEMDATA;
        regWriteRaw   = 1'b1;
        nextState     = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc  = 1'b1;
        memWriteRaw = 1'b1;
        nextState   = FETCH;
      end
      EXECUTER: begin
        bus.ALUSrcA = SRCA_REGA;
        aluOp       = ALUOP_FUNCT;
        nextState   = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcA = SRCA_REGA;
        bus.ALUSrcB = SRCB_IMM;
        aluOp       = ALUOP_FUNCT;
        nextState   = ALUWB;
      end
      ALUWB: begin
        regWriteRaw = 1'b1;
        nextState   = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA = SRCA_REGA;
        aluOp       = ALUOP_SUB;
        branch      = 1'b1;
        nextState   = FETCH;
      end
      JAL: begin
        // PC <= target while OldPC+4 is computed for the link writeback.
        bus.ALUSrcA = SRCA_OLDPC;
        bus.ALUSrcB = SRCB_FOUR;
        pcUpdate    = 1'b1;
        nextState   = ALUWB;
      end
      default: nextState = FETCH;
    endcase
  end

  // The state register already sits in FETCH during reset, whose Moore
  // outputs include write strobes; gate them so nothing commits while held.
  assign bus.PCWrite  = ~RESET & (pcUpdate | (branch & bus.Zero));
  assign bus.IRWrite  = ~RESET & irWriteRaw;
  assign bus.RegWrite = ~RESET & regWriteRaw;
  assign bus.MemWrite = ~RESET & memWriteRaw;
  assign bus.ImmSrc   = immSrcOf(bus.Opcode);

  alu_decoder uAluDecoder (
    .ALUOp      (aluOp),
    .Funct3     (bus.Funct3),
    .Funct7b5   (bus.Funct7b5),
    .Op5        (bus.Opcode[5]),
    .ALUControl (bus.ALUControl)
  );

endmodule
